vga_board_fetch: RTL and testbench

//  Downstream consumer of the processor's data memory.
//  - On each VGA frame_start, reads the snake game board (NUM_WORDS words at BASE_ADDR) through the second dmem port.
//  - Presents the board as one flat snake_data bus to the VGA renderer.
//  - Sits between skeleton's dmem VGA port (address_dmem_fromVGA/q_dmem_toVGA) and the pixel generator.

---
 rtl/vga_board_fetch_pkg.sv | 16 +
 rtl/vga_fetch_tag_pipe.sv | 37 +++
 rtl/vga_board_fetch.sv | 143 ++++++++++++++
 tb/tb_vga_board_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_board_fetch_pkg.sv
// Shared constants for the VGA board fetcher: FSM encodings and the default
// board location in dmem, which must match the game software memory map.
package vga_board_fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int         BOARD_NUM_WORDS = 10;
    localparam logic [11:0] BOARD_BASE_ADDR = 12'd0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_fetch_tag_pipe.sv
// Shift register of {valid, idx} tags that tracks dmem reads in flight so each
// returning word can be matched to its board slot.
module vga_fetch_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic             valid_reg [DEPTH];
    logic [IDX_W-1:0] idx_reg   [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                idx_reg[i]   <= '0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            idx_reg[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                idx_reg[i]   <= idx_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_idx   = idx_reg[DEPTH-1];

endmodule

// File: rtl/vga_board_fetch.sv
// Fetches the snake board from dmem once per VGA frame and presents it flat.
// Define VGA_DOUBLE_BUFFER_EN to update snake_data atomically at fetch end.
module vga_board_fetch
    import vga_board_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 32,
    parameter int                NUM_WORDS = BOARD_NUM_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = BOARD_BASE_ADDR,
    parameter int                READ_LAT  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    output logic [ADDR_W-1:0]           address_dmem_fromVGA,
    output logic [DATA_W-1:0]           data_fromVGA,
    output logic                        wren_fromVGA,
    input  logic [DATA_W-1:0]           q_dmem_toVGA,
    output logic [NUM_WORDS*DATA_W-1:0] snake_data,
    output logic                        board_valid,
    output logic                        busy
);

    localparam int               IDX_W    = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              pending_reg;
    logic              busy_reg;
    logic              valid_reg;

    logic              issue;
    logic              cap_valid;
    logic [IDX_W-1:0]  cap_idx;
    logic              done;

    assign issue = (state_reg == ST_ISSUE);
    assign done  = (state_reg == ST_DRAIN) && cap_valid && (cap_idx == LAST_IDX);

    vga_fetch_tag_pipe #(
        .DEPTH (READ_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (issue),
        .in_idx    (idx_reg),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    // A frame_start that arrives while any fetch is in flight (including on
    // the completing edge) is remembered and replayed once from IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            addr_reg    <= BASE_ADDR;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (frame_start || pending_reg) begin
                        state_reg   <= ST_ISSUE;
                        pending_reg <= 1'b0;
                        idx_reg     <= '0;
                        addr_reg    <= BASE_ADDR;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (frame_start) pending_reg <= 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        idx_reg  <= idx_reg + IDX_W'(1);
                        addr_reg <= BASE_ADDR + ADDR_W'(idx_reg + IDX_W'(1));
                    end
                end
                ST_DRAIN: begin
                    if (frame_start) pending_reg <= 1'b1;
                    if (done) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;
            logic              hit;

            assign hit = cap_valid && (cap_idx == IDX_W'(gi));

`ifdef VGA_DOUBLE_BUFFER_EN
            logic [DATA_W-1:0] shadow_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= '0;
                end else if (hit) begin
                    shadow_reg <= q_dmem_toVGA;
                end
            end

            // The last word lands on the same edge as the commit, so bypass it.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (done) begin
                    word_reg <= hit ? q_dmem_toVGA : shadow_reg;
                end
            end
`else
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (hit) begin
                    word_reg <= q_dmem_toVGA;
                end
            end
`endif

            assign snake_data[gi*DATA_W +: DATA_W] = word_reg;
        end
    endgenerate

    assign address_dmem_fromVGA = addr_reg;
    assign data_fromVGA         = '0;
    assign wren_fromVGA         = 1'b0;
    assign board_valid          = valid_reg;
    assign busy                 = busy_reg;

endmodule

// File: tb/tb_vga_board_fetch.sv
// Bench for vga_board_fetch: three instances (base 0/lat 1, base FFC/lat 1,
// base 0/lat 2) sharing one dmem image, checked every cycle against a model.
module tb_vga_board_fetch;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int AW = 12;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic frame_start;
    logic [31:0] mem [4096];

    logic [AW-1:0]   addr [3];
    logic [DW-1:0]   wdat [3];
    logic            wren [3];
    logic [DW-1:0]   q    [3];
    logic [N*DW-1:0] sd   [3];
    logic            bv   [3];
    logic            bsy  [3];

    vga_board_fetch #(.BASE_ADDR(12'h000), .READ_LAT(1)) dut0 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .address_dmem_fromVGA(addr[0]), .data_fromVGA(wdat[0]), .wren_fromVGA(wren[0]),
        .q_dmem_toVGA(q[0]), .snake_data(sd[0]), .board_valid(bv[0]), .busy(bsy[0]));

    vga_board_fetch #(.BASE_ADDR(12'hFFC), .READ_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .address_dmem_fromVGA(addr[1]), .data_fromVGA(wdat[1]), .wren_fromVGA(wren[1]),
        .q_dmem_toVGA(q[1]), .snake_data(sd[1]), .board_valid(bv[1]), .busy(bsy[1]));

    vga_board_fetch #(.BASE_ADDR(12'h000), .READ_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .address_dmem_fromVGA(addr[2]), .data_fromVGA(wdat[2]), .wren_fromVGA(wren[2]),
        .q_dmem_toVGA(q[2]), .snake_data(sd[2]), .board_valid(bv[2]), .busy(bsy[2]));

    // dmem with registered reads of READ_LAT stages
    logic [31:0] p0, p1, p2a, p2b;
    always @(posedge clock) begin
        p0  <= mem[addr[0]];
        p1  <= mem[addr[1]];
        p2a <= mem[addr[2]];
        p2b <= p2a;
    end
    assign q[0] = p0;
    assign q[1] = p1;
    assign q[2] = p2b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic logic [11:0] base_of(input int k);
        return (k == 1) ? 12'hFFC : 12'h000;
    endfunction

    // Model: a fetch is a window of N+L busy cycles numbered t=1..N+L.
    // Cycle t<=N presents address base+t-1; word j arrives in cycle j+1+L.
    logic        m_active [3];
    int          m_t      [3];
    logic        m_pend   [3];
    logic        m_bv     [3];
    logic [11:0] m_addr   [3];
    logic [31:0] m_board  [3][N];
    logic [31:0] m_snap   [3][N];

    int   rises    [3];
    int   run_len  [3];
    int   last_run [3];
    logic prev_bsy [3];
    int   mixed = 0;

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_active[k] = 1'b0;
                m_t[k]      = 0;
                m_pend[k]   = 1'b0;
                m_bv[k]     = 1'b0;
                m_addr[k]   = base_of(k);
                for (int j = 0; j < N; j++) m_board[k][j] = '0;
            end

            chk("busy", k, 32'(bsy[k]), 32'(m_active[k]));
            chk("board_valid", k, 32'(bv[k]), 32'(m_bv[k]));
            chk("address", k, 32'(addr[k]), 32'(m_addr[k]));
            chk("wren", k, 32'(wren[k]), 32'd0);
            chk("wdata", k, wdat[k], 32'd0);
            for (int j = 0; j < N; j++)
                chk($sformatf("word%0d", j), k, sd[k][j*DW +: DW], m_board[k][j]);

            if (bsy[k] && !prev_bsy[k]) rises[k]++;
            if (bsy[k]) run_len[k]++;
            else if (prev_bsy[k]) begin
                last_run[k] = run_len[k];
                run_len[k]  = 0;
            end
            prev_bsy[k] = bsy[k];

            if (reset) begin
                if (!m_active[k]) begin
                    if (frame_start || m_pend[k]) begin
                        m_active[k] = 1'b1;
                        m_t[k]      = 1;
                        m_pend[k]   = 1'b0;
                        m_addr[k]   = base_of(k);
                        for (int j = 0; j < N; j++) begin
                            logic [11:0] a;
                            a = base_of(k) + 12'(j);
                            m_snap[k][j] = mem[a];
                        end
                    end
                end else begin
                    if (frame_start) m_pend[k] = 1'b1;
`ifndef VGA_DOUBLE_BUFFER_EN
                    for (int j = 0; j < N; j++)
                        if (m_t[k] == j + 1 + lat_of(k)) m_board[k][j] = m_snap[k][j];
`endif
                    if (m_t[k] == N + lat_of(k)) begin
                        m_active[k] = 1'b0;
                        m_bv[k]     = 1'b1;
`ifdef VGA_DOUBLE_BUFFER_EN
                        for (int j = 0; j < N; j++) m_board[k][j] = m_snap[k][j];
`endif
                    end else begin
                        m_t[k]++;
                        if (m_t[k] <= N) m_addr[k] = base_of(k) + 12'(m_t[k] - 1);
                    end
                end
            end
        end
        if (sd[0][31:0] == 32'h200 && sd[0][9*DW +: DW] == 32'h109) mixed++;
        cyc++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // frame_start high for the current cycle; returns one cycle later
    task automatic pulse();
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rises[k] = 0; run_len[k] = 0; last_run[k] = 0; prev_bsy[k] = 1'b0;
        end
        for (int a = 0; a < 4096; a++) mem[a] = 32'h100 + 32'(a);

        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);

        // single fetch
        pulse();
        wait_cyc(20);
        for (int j = 0; j < N; j++) chk($sformatf("t1_word%0d", j), 0, sd[0][j*DW +: DW], 32'h100 + 32'(j));
        chk("t1_valid", 0, 32'(bv[0]), 32'd1);
        chk("t1_busy_len", 0, 32'(last_run[0]), 32'd11);
        chk("t6_busy_len", 2, 32'(last_run[2]), 32'd12);
        chk("t1_word7", 2, sd[2][7*DW +: DW], 32'h107);
        chk("t1_rises", 0, 32'(rises[0]), 32'd1);

        // three pulses during a fetch coalesce into one extra
        pulse();
        wait_cyc(2); pulse();
        wait_cyc(1); pulse();
        wait_cyc(1); pulse();
        wait_cyc(40);
        chk("t2_rises", 0, 32'(rises[0]), 32'd3);
        chk("t2_rises", 2, 32'(rises[2]), 32'd3);

        // pulse on dut0's completing cycle is still honoured
        pulse();
        wait_cyc(10); pulse();
        wait_cyc(40);
        chk("t2b_rises", 0, 32'(rises[0]), 32'd5);

        // reset during the 4th issue cycle
        pulse();
        wait_cyc(3);
        reset = 1'b0;
        #1;
        chk("t3_busy", 0, 32'(bsy[0]), 32'd0);
        chk("t3_valid", 0, 32'(bv[0]), 32'd0);
        chk("t3_word0", 0, sd[0][31:0], 32'd0);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(20);
        chk("t3_rises", 0, 32'(rises[0]), 32'd6);
        chk("t3_word1", 0, sd[0][DW +: DW], 32'd0);

        // refetch old image, then new image
        pulse();
        wait_cyc(20);
        for (int a = 0; a < N; a++) mem[a] = 32'h200 + 32'(a);
        pulse();
        wait_cyc(20);
        for (int j = 0; j < N; j++) chk($sformatf("t5_word%0d", j), 0, sd[0][j*DW +: DW], 32'h200 + 32'(j));
`ifdef VGA_DOUBLE_BUFFER_EN
        chk("t5_mixed_cycles", 0, 32'(mixed), 32'd0);
`else
        chk("t5_mixed_seen", 0, 32'(mixed > 0), 32'd1);
`endif
        chk("t4_word0", 1, sd[1][0*DW +: DW], 32'h10FC);
        chk("t4_word3", 1, sd[1][3*DW +: DW], 32'h10FF);
        chk("t4_word4", 1, sd[1][4*DW +: DW], 32'h200);
        chk("t4_word9", 1, sd[1][9*DW +: DW], 32'h205);
        chk("t6_word5", 2, sd[2][5*DW +: DW], 32'h205);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
